// File: rtl/mat_pkg.sv
// -----------------------------------------------------------------------------
// mat_pkg
//
// Shared types for the matrix register and its command sequencer.
//   mat_elem_t        one matrix element, carried as the 32-bit shortreal bit
//                     pattern so the data path stays synthesizable
//   MatDataReadOp_t   matrix register read op
//   MatDataWriteOp_t  matrix register write op
//   MatCtrlOp_t       block command accepted by mat_reg_ctrl
//   MatCtrlState_t    mat_reg_ctrl sequencer state
// -----------------------------------------------------------------------------
package mat_pkg;

  typedef logic [31:0] mat_elem_t;

  typedef enum logic [1:0] {
    MAT_RD_DISABLE = 2'd0,
    MAT_RD_ROW     = 2'd1,
    MAT_RD_COL     = 2'd2,
    MAT_RD_SCALAR  = 2'd3
  } MatDataReadOp_t;

  typedef enum logic [2:0] {
    MAT_WR_DISABLE   = 3'd0,
    MAT_WR_ROW       = 3'd1,
    MAT_WR_COL       = 3'd2,
    MAT_WR_SCALAR    = 3'd3,
    MAT_WR_TRANSPOSE = 3'd4,
    MAT_WR_XFLIP     = 3'd5,
    MAT_WR_YFLIP     = 3'd6
  } MatDataWriteOp_t;

  typedef enum logic [2:0] {
    CTRL_LOAD_ROW  = 3'd0,
    CTRL_LOAD_COL  = 3'd1,
    CTRL_STORE_ROW = 3'd2,
    CTRL_STORE_COL = 3'd3,
    CTRL_TRANSPOSE = 3'd4,
    CTRL_XFLIP     = 3'd5,
    CTRL_YFLIP     = 3'd6
  } MatCtrlOp_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2,
    ST_XFORM = 2'd3
  } MatCtrlState_t;

  // Whole-matrix transform requested by a command; DISABLE for non-transforms.
  function automatic MatDataWriteOp_t xform_write_op(input MatCtrlOp_t op);
    case (op)
      CTRL_TRANSPOSE: return MAT_WR_TRANSPOSE;
      CTRL_XFLIP:     return MAT_WR_XFLIP;
      CTRL_YFLIP:     return MAT_WR_YFLIP;
      default:        return MAT_WR_DISABLE;
    endcase
  endfunction

endpackage

// File: rtl/mat_reg_ctrl.sv
// -----------------------------------------------------------------------------
// mat_reg_ctrl
//
// Command sequencer for one matrix register. Takes one block command at a time
// (load/store rows or columns, transpose, x/y flip) and drives the register's
// op/param ports cycle by cycle, streaming vectors in and out over valid/ready.
//
// Parameters
//   WIDTH            matrix dimension (must match the attached register)
//   WIDTH_ADDR_SIZE  row/column index width
//
// Ports
//   clock, reset_n                      clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_op,
//   cmd_start, cmd_count                command handshake (ready iff IDLE)
//   in_valid/in_ready, in_data          load-data stream
//   out_valid/out_ready, out_data       store-data stream
//   mat_read_op/param1/param2           matrix register read port
//   mat_write_op/param1/param2          matrix register write port
//   mat_data_in, mat_data_out           matrix register data ports
//   done                                one-cycle pulse on completion
//   error                               one-cycle pulse on rejected command
//
// Configuration
//   MAT_REG_CTRL_BOUNDS_CHECK_EN  when defined, a LOAD/STORE with
//   start+count > WIDTH is accepted but dropped and error pulses; when
//   undefined indices wrap modulo WIDTH and error is tied 0.
// -----------------------------------------------------------------------------
module mat_reg_ctrl
  import mat_pkg::*;
#(
  parameter int WIDTH           = 128,
  parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH)
) (
  input  logic                       clock,
  input  logic                       reset_n,

  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  MatCtrlOp_t                 cmd_op,
  input  logic [WIDTH_ADDR_SIZE-1:0] cmd_start,
  input  logic [WIDTH_ADDR_SIZE:0]   cmd_count,

  input  logic                       in_valid,
  output logic                       in_ready,
  input  mat_elem_t                  in_data [WIDTH],

  output logic                       out_valid,
  input  logic                       out_ready,
  output mat_elem_t                  out_data [WIDTH],

  output MatDataReadOp_t             mat_read_op,
  output logic [WIDTH_ADDR_SIZE-1:0] mat_read_param1,
  output logic [WIDTH_ADDR_SIZE-1:0] mat_read_param2,
  output MatDataWriteOp_t            mat_write_op,
  output logic [WIDTH_ADDR_SIZE-1:0] mat_write_param1,
  output logic [WIDTH_ADDR_SIZE-1:0] mat_write_param2,
  output mat_elem_t                  mat_data_in [WIDTH],
  input  mat_elem_t                  mat_data_out [WIDTH],

  output logic                       done,
  output logic                       error
);

  // Index/count width: one extra bit so a count of WIDTH is representable.
  localparam int IDX_W = WIDTH_ADDR_SIZE + 1;
  localparam logic [IDX_W-1:0] WIDTH_IDX = IDX_W'(WIDTH);

  MatCtrlState_t              state_q, state_d;
  MatCtrlOp_t                 op_q, op_d;
  logic [WIDTH_ADDR_SIZE-1:0] start_q, start_d;
  logic [IDX_W-1:0]           count_q, count_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       done_q, done_d;

  logic [IDX_W-1:0]           addr_sum;
  logic [WIDTH_ADDR_SIZE-1:0] cur_addr;
  logic                       last_beat;

  // Data never passes through a register: vectors flow straight between the
  // streams and the matrix register, only the control is sequenced here.
  assign mat_data_in = in_data;
  assign out_data    = mat_data_out;

  // Scalar ops are never issued, so the second parameter is unused.
  assign mat_read_param2  = '0;
  assign mat_write_param2 = '0;

  // start < WIDTH and idx < WIDTH, so one conditional subtract is an exact
  // modulo-WIDTH even when WIDTH is not a power of two.
  assign addr_sum  = {1'b0, start_q} + idx_q;
  assign cur_addr  = (addr_sum >= WIDTH_IDX) ? WIDTH_ADDR_SIZE'(addr_sum - WIDTH_IDX)
                                             : WIDTH_ADDR_SIZE'(addr_sum);
  assign last_beat = (idx_q + IDX_W'(1)) == count_q;

`ifdef MAT_REG_CTRL_BOUNDS_CHECK_EN
  logic cmd_oob;
  logic error_q, error_d;

  // Width IDX_W holds (WIDTH-1)+WIDTH without overflow.
  assign cmd_oob = ({1'b0, cmd_start} + cmd_count) > WIDTH_IDX;
  assign error   = error_q;
`else
  assign error   = 1'b0;
`endif

  assign done = done_q;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d          = state_q;
    op_d             = op_q;
    start_d          = start_q;
    count_d          = count_q;
    idx_d            = idx_q;
    done_d           = 1'b0;
`ifdef MAT_REG_CTRL_BOUNDS_CHECK_EN
    error_d          = 1'b0;
`endif
    cmd_ready        = 1'b0;
    in_ready         = 1'b0;
    out_valid        = 1'b0;
    mat_read_op      = MAT_RD_DISABLE;
    mat_read_param1  = '0;
    mat_write_op     = MAT_WR_DISABLE;
    mat_write_param1 = '0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          start_d = cmd_start;
          count_d = cmd_count;
          idx_d   = '0;
          case (cmd_op)
            CTRL_LOAD_ROW, CTRL_LOAD_COL,
            CTRL_STORE_ROW, CTRL_STORE_COL: begin
              // An empty transfer completes without leaving IDLE.
              if (cmd_count == '0) begin
                done_d = 1'b1;
              end
`ifdef MAT_REG_CTRL_BOUNDS_CHECK_EN
              else if (cmd_oob) begin
                error_d = 1'b1;
              end
`endif
              else if (cmd_op == CTRL_LOAD_ROW || cmd_op == CTRL_LOAD_COL) begin
                state_d = ST_LOAD;
              end else begin
                state_d = ST_STORE;
              end
            end
            CTRL_TRANSPOSE, CTRL_XFLIP, CTRL_YFLIP: state_d = ST_XFORM;
            // Unencoded op: nothing to do, complete immediately.
            default: done_d = 1'b1;
          endcase
        end
      end

      ST_LOAD: begin
        in_ready         = 1'b1;
        mat_write_param1 = cur_addr;
        if (in_valid) begin
          mat_write_op = (op_q == CTRL_LOAD_COL) ? MAT_WR_COL : MAT_WR_ROW;
          idx_d        = idx_q + IDX_W'(1);
          if (last_beat) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      ST_STORE: begin
        // Op and address depend only on registered state, so they hold
        // steady across an out_ready stall.
        out_valid       = 1'b1;
        mat_read_op     = (op_q == CTRL_STORE_COL) ? MAT_RD_COL : MAT_RD_ROW;
        mat_read_param1 = cur_addr;
        if (out_ready) begin
          idx_d = idx_q + IDX_W'(1);
          if (last_beat) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      ST_XFORM: begin
        mat_write_op = xform_write_op(op_q);
        state_d      = ST_IDLE;
        done_d       = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= CTRL_LOAD_ROW;
      start_q <= '0;
      count_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      op_q    <= op_d;
      start_q <= start_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

`ifdef MAT_REG_CTRL_BOUNDS_CHECK_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end
`endif

endmodule

// File: tb/tb_mat_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mat_reg_ctrl
//
// Directed bench for mat_reg_ctrl with WIDTH=4. A behavioural 4x4 matrix
// register is attached to the DUT. Expected register writes and expected store
// vectors are queued as stimulus is driven and popped by a monitor when the
// DUT performs the write or completes a store handshake.
// Inputs change on the falling edge; checks sample shortly after it.
// -----------------------------------------------------------------------------
module tb_mat_reg_ctrl;
  import mat_pkg::*;

  localparam int W  = 4;
  localparam int AW = 2;

  logic            clock;
  logic            reset_n;
  logic            cmd_valid;
  logic            cmd_ready;
  MatCtrlOp_t      cmd_op;
  logic [AW-1:0]   cmd_start;
  logic [AW:0]     cmd_count;
  logic            in_valid;
  logic            in_ready;
  mat_elem_t       in_data [W];
  logic            out_valid;
  logic            out_ready;
  mat_elem_t       out_data [W];
  MatDataReadOp_t  mat_read_op;
  logic [AW-1:0]   mat_read_param1;
  logic [AW-1:0]   mat_read_param2;
  MatDataWriteOp_t mat_write_op;
  logic [AW-1:0]   mat_write_param1;
  logic [AW-1:0]   mat_write_param2;
  mat_elem_t       mat_data_in [W];
  mat_elem_t       mat_data_out [W];
  logic            done;
  logic            error;

  mat_reg_ctrl #(.WIDTH(W), .WIDTH_ADDR_SIZE(AW)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_start        (cmd_start),
    .cmd_count        (cmd_count),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .mat_read_op      (mat_read_op),
    .mat_read_param1  (mat_read_param1),
    .mat_read_param2  (mat_read_param2),
    .mat_write_op     (mat_write_op),
    .mat_write_param1 (mat_write_param1),
    .mat_write_param2 (mat_write_param2),
    .mat_data_in      (mat_data_in),
    .mat_data_out     (mat_data_out),
    .done             (done),
    .error            (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Behavioural matrix register (never reset)
  // ---------------------------------------------------------------------------
  logic [31:0] mat [W][W];

  always_comb begin
    for (int j = 0; j < W; j++) begin
      mat_data_out[j] = '0;
      if (mat_read_op == MAT_RD_ROW) mat_data_out[j] = mat[mat_read_param1][j];
      if (mat_read_op == MAT_RD_COL) mat_data_out[j] = mat[j][mat_read_param1];
    end
  end

  always @(posedge clock) begin
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W; c++) begin
        case (mat_write_op)
          MAT_WR_ROW:       if (r == int'(mat_write_param1)) mat[r][c] <= mat_data_in[c];
          MAT_WR_COL:       if (c == int'(mat_write_param1)) mat[r][c] <= mat_data_in[r];
          MAT_WR_TRANSPOSE: mat[r][c] <= mat[c][r];
          MAT_WR_XFLIP:     mat[r][c] <= mat[r][W-1-c];
          MAT_WR_YFLIP:     mat[r][c] <= mat[W-1-r][c];
          default: ;
        endcase
      end
    end
  end

  // Packed views of the data vectors, element j at bits [32j +: 32].
  logic [127:0] din_p, dout_p;
  always_comb begin
    din_p  = '0;
    dout_p = '0;
    for (int j = 0; j < W; j++) begin
      din_p[j*32 +: 32]  = mat_data_in[j];
      dout_p[j*32 +: 32] = out_data[j];
    end
  end

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    MatDataWriteOp_t op;
    logic [AW-1:0]   p1;
    logic [127:0]    data;
    logic            chk_data;
  } exp_wr_t;

  exp_wr_t      wr_q [$];
  logic [127:0] rd_q [$];
  exp_wr_t      e_wr;
  logic [127:0] e_rd;

  function automatic logic [127:0] row_vec(input logic [31:0] base);
    logic [127:0] v;
    for (int j = 0; j < W; j++) v[j*32 +: 32] = base + 32'(j);
    return v;
  endfunction

  // Monitor: late in the low phase, after stimulus settles, before the edge.
  always begin
    @(negedge clock);
    #4;
    if (reset_n) begin
      if (mat_write_op != MAT_WR_DISABLE) begin
        check("wr_expected", 128'(wr_q.size() != 0), 128'(1));
        if (wr_q.size() != 0) begin
          e_wr = wr_q.pop_front();
          check("wr_op", 128'(mat_write_op), 128'(e_wr.op));
          check("wr_param1", 128'(mat_write_param1), 128'(e_wr.p1));
          check("wr_param2", 128'(mat_write_param2), 128'(0));
          if (e_wr.chk_data) check("wr_data", din_p, e_wr.data);
        end
      end
      if (out_valid && out_ready) begin
        check("rd_expected", 128'(rd_q.size() != 0), 128'(1));
        if (rd_q.size() != 0) begin
          e_rd = rd_q.pop_front();
          check("rd_data", dout_p, e_rd);
          check("rd_param2", 128'(mat_read_param2), 128'(0));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (each starts and ends on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic set_in(input logic [31:0] base);
    for (int j = 0; j < W; j++) in_data[j] = base + 32'(j);
  endtask

  task automatic send_cmd(input MatCtrlOp_t op, input int start, input int count);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_start = AW'(start);
    cmd_count = (AW+1)'(count);
    #1;
    check("cmd_ready_accept", 128'(cmd_ready), 128'(1));
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic load_beat(input int addr, input logic [31:0] base);
    exp_wr_t e;
    in_valid = 1'b1;
    set_in(base);
    e.op = MAT_WR_ROW; e.p1 = AW'(addr); e.data = row_vec(base); e.chk_data = 1'b1;
    wr_q.push_back(e);
    #1;
    check("load_in_ready", 128'(in_ready), 128'(1));
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic store_beat(input int addr, input logic [127:0] exp_vec);
    out_ready = 1'b1;
    rd_q.push_back(exp_vec);
    #1;
    check("store_out_valid", 128'(out_valid), 128'(1));
    check("store_param1", 128'(mat_read_param1), 128'(addr));
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    #1;
    check({tag, "_done"}, 128'(done), 128'(1));
    check({tag, "_cmd_ready"}, 128'(cmd_ready), 128'(1));
  endtask

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    exp_wr_t ex;

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = CTRL_LOAD_ROW;
    cmd_start = '0;
    cmd_count = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_in(32'd0);
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++) mat[r][c] = '0;

    repeat (2) @(negedge clock);
    #1;
    check("rst_done", 128'(done), 128'(0));
    check("rst_error", 128'(error), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_read_op", 128'(mat_read_op), 128'(MAT_RD_DISABLE));
    check("rst_write_op", 128'(mat_write_op), 128'(MAT_WR_DISABLE));
    check("rst_params", {mat_read_param1, mat_read_param2, mat_write_param1, mat_write_param2},
          128'(0));
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("post_rst_cmd_ready", 128'(cmd_ready), 128'(1));
    @(negedge clock);

    // 1: load four rows, read column 1 back.
    send_cmd(CTRL_LOAD_ROW, 0, 4);
    for (int r = 0; r < W; r++) load_beat(r, 32'(4*r + 1));
    expect_done("load4");
    @(negedge clock);
    #1;
    check("load4_done_once", 128'(done), 128'(0));
    @(negedge clock);
    send_cmd(CTRL_STORE_COL, 1, 1);
    store_beat(1, {32'd14, 32'd10, 32'd6, 32'd2});
    expect_done("storecol");
    @(negedge clock);

    // Empty load: stays idle, done next cycle.
    send_cmd(CTRL_LOAD_ROW, 0, 0);
    expect_done("count0");
    check("count0_in_ready", 128'(in_ready), 128'(0));
    @(negedge clock);

    // 2: wrapping load with in_valid toggling.
    send_cmd(CTRL_LOAD_ROW, 3, 2);
    load_beat(3, 32'd100);
    #1;
    check("gap_write_op", 128'(mat_write_op), 128'(MAT_WR_DISABLE));
    check("gap_in_ready", 128'(in_ready), 128'(1));
    @(negedge clock);
    load_beat(0, 32'd200);
    expect_done("wrapload");
    @(negedge clock);

    // 3: store three rows with a two-cycle stall on beat 1.
    send_cmd(CTRL_STORE_ROW, 1, 3);
    store_beat(1, row_vec(32'd5));
    for (int s = 0; s < 2; s++) begin
      out_ready = 1'b0;
      #1;
      check("stall_param1", 128'(mat_read_param1), 128'(2));
      check("stall_out_valid", 128'(out_valid), 128'(1));
      check("stall_read_op", 128'(mat_read_op), 128'(MAT_RD_ROW));
      @(negedge clock);
    end
    store_beat(2, row_vec(32'd9));
    store_beat(3, row_vec(32'd100));
    expect_done("stallstore");
    @(negedge clock);

    // 4: transpose, then read row 0 with a store accepted in the done cycle.
    ex.op = MAT_WR_TRANSPOSE; ex.p1 = '0; ex.data = '0; ex.chk_data = 1'b0;
    wr_q.push_back(ex);
    send_cmd(CTRL_TRANSPOSE, 0, 0);
    #1;
    check("xform_write_op", 128'(mat_write_op), 128'(MAT_WR_TRANSPOSE));
    check("xform_cmd_ready", 128'(cmd_ready), 128'(0));
    check("xform_done_early", 128'(done), 128'(0));
    @(negedge clock);
    #1;
    check("xform_write_op_once", 128'(mat_write_op), 128'(MAT_WR_DISABLE));
    expect_done("xform");
    send_cmd(CTRL_STORE_ROW, 0, 1);
    store_beat(0, {32'd100, 32'd9, 32'd5, 32'd200});
    expect_done("post_xform");
    @(negedge clock);

    // 5: load that crosses the end of the matrix.
    send_cmd(CTRL_LOAD_ROW, 2, 3);
`ifdef MAT_REG_CTRL_BOUNDS_CHECK_EN
    #1;
    check("oob_error", 128'(error), 128'(1));
    check("oob_done", 128'(done), 128'(0));
    check("oob_in_ready", 128'(in_ready), 128'(0));
    check("oob_write_op", 128'(mat_write_op), 128'(MAT_WR_DISABLE));
    @(negedge clock);
    #1;
    check("oob_error_pulse", 128'(error), 128'(0));
    check("oob_no_done", 128'(done), 128'(0));
    @(negedge clock);
`else
    load_beat(2, 32'd300);
    load_beat(3, 32'd310);
    load_beat(0, 32'd320);
    expect_done("oob_wrap");
    check("oob_wrap_error", 128'(error), 128'(0));
    @(negedge clock);
`endif

    // 6: reset during beat 2 of a four-row load.
    send_cmd(CTRL_LOAD_ROW, 0, 4);
    load_beat(0, 32'd400);
    load_beat(1, 32'd410);
    in_valid = 1'b1;
    set_in(32'd420);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_in_ready", 128'(in_ready), 128'(0));
    check("abort_write_op", 128'(mat_write_op), 128'(MAT_WR_DISABLE));
    check("abort_read_op", 128'(mat_read_op), 128'(MAT_RD_DISABLE));
    check("abort_done", 128'(done), 128'(0));
    check("abort_param1", 128'(mat_write_param1), 128'(0));
    @(negedge clock);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    check("abort_cmd_ready", 128'(cmd_ready), 128'(1));
    @(negedge clock);
    send_cmd(CTRL_STORE_ROW, 0, 2);
    store_beat(0, row_vec(32'd400));
    store_beat(1, row_vec(32'd410));
    expect_done("retained");
    @(negedge clock);

    repeat (2) @(negedge clock);
    check("wr_queue_drained", 128'(wr_q.size()), 128'(0));
    check("rd_queue_drained", 128'(rd_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mat_reg_ctrl.md
# mat_reg_ctrl

Command sequencer for the matrix register. Accepts one block command at a time (load rows/cols, store rows/cols, transpose, flip) over a valid/ready interface. Drives the matrix register's read/write op and parameter ports cycle by cycle, streaming data vectors in and out with valid/ready handshakes. Sits between the tile's instruction decoder and one matrix register instance.

## Interface
- WIDTH, 128, matrix dimension; must match the attached matrix register
- WIDTH_ADDR_SIZE, $clog2(WIDTH), row/column index width
- clock  input  1  sole clock; all state updates on posedge
- reset_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  high iff state IDLE
- cmd_op  input  MatCtrlOp_t  LOAD_ROW, LOAD_COL, STORE_ROW, STORE_COL, TRANSPOSE, XFLIP, YFLIP
- cmd_start  input  WIDTH_ADDR_SIZE  first row/col index
- cmd_count  input  WIDTH_ADDR_SIZE+1  number of rows/cols, 0..WIDTH
- in_valid / in_ready  input / output  1  load-data handshake
- in_data  input  shortreal[WIDTH]  load vector, passed straight to mat_data_in
- out_valid / out_ready  output / input  1  store-data handshake
- out_data  output  shortreal[WIDTH]  equals mat_data_out (combinational)
- mat_read_op, mat_read_param1, mat_read_param2  output  MatDataReadOp_t, WIDTH_ADDR_SIZE x2  to matrix register
- mat_write_op, mat_write_param1, mat_write_param2  output  MatDataWriteOp_t, WIDTH_ADDR_SIZE x2  to matrix register
- mat_data_in  output / mat_data_out  input  shortreal[WIDTH]  matrix register data ports
- done  output  1  one-cycle pulse on command completion
- error  output  1  one-cycle pulse on rejected command; tied 0 without the config macro

## Operation
- States: IDLE, LOAD, STORE, XFORM.
- IDLE: on cmd_valid && cmd_ready, register op, start, count; clear idx.
  - Next state is LOAD/STORE/XFORM by op.
  - count==0 on LOAD/STORE stays IDLE and pulses done next cycle.
- LOAD: in_ready=1. On each in_valid && in_ready beat:
  - mat_write_op=ROW (or COL); param1=(start+idx) mod WIDTH; idx++.
  - Outside a beat, mat_write_op=DISABLE.
- STORE: mat_read_op=ROW (or COL); param1=(start+idx) mod WIDTH; out_valid=1.
  - read_op and param1 held stable while out_valid && !out_ready; idx++ on handshake.
- XFORM: mat_write_op=TRANSPOSE/XFLIP/YFLIP for exactly one cycle, then IDLE.
- Completion: after beat idx==count-1 (or the XFORM cycle), next state IDLE and done=1 for that next cycle.
- mat_read_param2 and mat_write_param2 are always 0; scalar ops are never issued.
- Any state other than the ones above drives DISABLE on both matrix-register ops.

## Timing
- Reset values: state IDLE, idx 0, done 0, error 0, in_ready 0, out_valid 0, both ops DISABLE, params 0.
  - cmd_ready=1 in the first cycle after reset_n deasserts.
- Command accepted at edge t: first data beat possible in cycle t+1. XFORM write occurs at edge t+1; done is high in cycle t+1..t+2.
- Load of N rows at full throughput: N cycles plus 1 accept cycle. Store is likewise N+1.
- Write committed at the edge of the handshake; a STORE accepted the next cycle reads the new data.
- Index wraps modulo WIDTH: start=WIDTH-1, count=2 touches rows WIDTH-1 then 0.
- reset_n asserted mid-command: abort immediately, all outputs to reset values. Rows already written are retained; the matrix register is not reset.
- Only one command in flight; cmd_ready=0 until the done cycle.
  - A new command may be accepted in the done cycle.

## Configuration
- MAT_REG_CTRL_BOUNDS_CHECK_EN defined:
  - LOAD/STORE with start+count > WIDTH is accepted (cmd_ready handshake completes) but not executed.
  - error pulses for one cycle next cycle; done stays 0; state stays IDLE.
- Undefined: no check; indices wrap modulo WIDTH; error tied 0.

## Structure
- Shared package mat_pkg holds:
  - existing MatDataReadOp_t and MatDataWriteOp_t;
  - new MatCtrlOp_t enum;
  - MatCtrlState_t enum for IDLE/LOAD/STORE/XFORM.
- Single module, no sub-modules. The index counter and FSM are small enough to inline.

## Test plan
All scenarios use WIDTH=4.
- LOAD_ROW start=0 count=4 with rows {1..4},{5..8},{9..12},{13..16}, then STORE_COL start=1 count=1 -> out_data={2,6,10,14}; done pulses once per command.
- LOAD_ROW start=3 count=2, in_valid toggling every other cycle -> rows 3 then 0 written; 2 beats over 4 cycles; mat_write_op DISABLE on idle cycles.
- STORE_ROW count=3 with out_ready low for 2 cycles on beat 1 -> mat_read_param1 held at start+1 during stall; 3 beats total.
- TRANSPOSE -> mat_write_op=TRANSPOSE for exactly one cycle at t+1; done at t+2; cmd_ready low only during cycle t+1.
- With MAT_REG_CTRL_BOUNDS_CHECK_EN, LOAD_ROW start=2 count=3 -> error=1 one cycle, no write_op, done=0. Without the macro -> rows 2,3,0 written.
- reset_n pulsed low during beat 2 of a 4-row LOAD -> outputs return to reset values; rows 0,1 retain loaded data; cmd_ready=1 after release.
